cp0_exc: RTL and testbench
==========================

# cp0_exc

Coprocessor-0 register file and exception controller for the MIPS core. It consumes the exception flags raised in execute/memory, including the ALU's signed add/sub overflow flag, plus the pipeline's PC. It holds the architectural BadVAddr, Count, Compare, Status, Cause and EPC registers, arbitrates exception priority, and issues the pipeline flush with the redirect address for exception entry and `eret`.

## Interface
- No parameters; exception vector fixed at 32'hBFC0_0380.
- `clk` in 1: single clock; all state updates on rising edge.
- `rst` in 1: synchronous, active-high reset.
- `pc_i` in 32: PC of the instruction at the commit point (MEM stage).
- `in_delay_slot` in 1: that instruction sits in a branch delay slot.
- `exp_overflow` in 1: signed add/sub overflow from the ALU (pipelined to MEM).
- `exp_syscall`, `exp_break`, `exp_ri` in 1 each: syscall, break, reserved-instruction.
- `exp_adel`, `exp_ades` in 1 each: load/fetch and store address errors.
- `bad_vaddr_i` in 32: faulting address for AdEL/AdES.
- `hw_int` in 6: level-sensitive hardware interrupt lines.
- `eret` in 1: `eret` at commit point.
- `mtc0_we` in 1, `cp0_addr` in 5, `cp0_wdata` in 32: mtc0 write port.
- `cp0_rdata` out 32: combinational mfc0 read of register `cp0_addr`; unimplemented addresses read 0.
- `exc_flush` out 1: combinational; flush IF..MEM this cycle.
- `exc_target` out 32: redirect PC, valid when `exc_flush`=1.

## Operation
- Registers (addr: reset value):
  - BadVAddr (8): 0.
  - Count (9): 0.
  - Compare (11): 0.
  - Status (12): 32'h0040_0000. Fields: BEV[22] read-only 1, IM[15:8], EXL[1], IE[0]. Other bits read 0.
  - Cause (13): 0. Fields: BD[31], TI[30], IP[15:8], ExcCode[6:2]. Only IP[9:8] are writable.
  - EPC (14): 0.
- Interrupt pending: `int_req` = IE & ~EXL & |(Cause.IP & Status.IM).
  - Cause.IP[15:10] is registered each cycle from {hw_int[5]|TI, hw_int[4:0]}.
- Exception priority, first active wins: Int(0) > AdEL(4) > RI(10) > Ov(12) > Sys(8) > Bp(9) > AdES(5).
- Exception taken (any flag or `int_req`):
  - `exc_flush`=1 and `exc_target`=32'hBFC0_0380 in the same cycle.
  - At the edge: ExcCode gets the winner's code and EXL is set to 1.
  - If EXL was 0: EPC = in_delay_slot ? pc_i-4 : pc_i, and BD = in_delay_slot.
  - If EXL was already 1: EPC and BD are unchanged.
  - For AdEL/AdES: BadVAddr = bad_vaddr_i.
- `eret` with no exception: `exc_flush`=1, `exc_target`=EPC (current value), EXL cleared at the edge.
- Precedence rules:
  - An exception beats `eret` in the same cycle.
  - An exception suppresses `mtc0_we` in the same cycle.
  - `eret` and mtc0 never co-occur (the pipeline guarantees this).
- mtc0 writes take effect at the edge. `cp0_rdata` shows the new value the next cycle; there is no bypass.
- Count: a divide-by-2 tick toggles every cycle, and Count increments on tick=1, wrapping 32'hFFFF_FFFF -> 0.
  - An mtc0 to Count overrides the increment and clears the tick.
- TI is set at the edge where Count == Compare (pre-update values).
  - An mtc0 to Compare clears TI; the write wins over a same-cycle match.

## Timing
- `exc_flush`/`exc_target`: zero latency (combinational from inputs and current state).
- All register effects are visible on `cp0_rdata` one cycle after the triggering edge.
- Interrupts: `hw_int` reaches Cause.IP at edge N, so `int_req` can assert in cycle N+1 (1-cycle latency).
- Reset asserted mid-exception: all registers return to reset values at that edge. `exc_flush` is 0 while `rst`=1.
- `exc_flush` is held 0 for every cycle `rst` is high, regardless of inputs.

## Test plan
- Overflow at pc_i=32'h8000_1000, not in a delay slot:
  - Same cycle: `exc_flush`=1, target 32'hBFC0_0380.
  - Next cycle: EPC=32'h8000_1000, Cause.ExcCode=12, Status.EXL=1.
- Syscall in a delay slot at pc_i=32'h8000_2004, with `exp_ades` also high:
  - Sys wins.
  - EPC=32'h8000_2000, Cause.BD=1, ExcCode=8.
- Nested exception: RI raised while EXL=1 at pc_i=32'h8000_3000.
  - EPC unchanged, ExcCode=10, flush to 32'hBFC0_0380.
  - Then `eret`: target = the old EPC, EXL=0 next cycle.
- Interrupt path: mtc0 Status=32'h0000_0401 (IM2, IE), then hw_int=6'b000001.
  - Cause.IP[10]=1 one cycle later.
  - Flush the following cycle with ExcCode=0.
  - An AdEL presented in that same cycle loses (Int wins).
- Timer: mtc0 Compare=10, mtc0 Count=0.
  - TI=1 about 20 cycles later.
  - mtc0 Compare=20 clears TI.
  - Count=32'hFFFF_FFFF wraps to 0 after 2 cycles.
- mtc0 to EPC in the same cycle as an overflow: the write is dropped and EPC=pc_i. Then assert `rst` mid-operation: Status reads 32'h0040_0000 and all other registers read 0.

Source files
------------

// File: rtl/cp0_exc.sv
// Coprocessor-0 register file and exception controller: holds BadVAddr, Count,
// Compare, Status, Cause and EPC, picks the winning exception, and redirects the pipeline.
module cp0_exc (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] pc_i,
  input  logic        in_delay_slot,
  input  logic        exp_overflow,
  input  logic        exp_syscall,
  input  logic        exp_break,
  input  logic        exp_ri,
  input  logic        exp_adel,
  input  logic        exp_ades,
  input  logic [31:0] bad_vaddr_i,
  input  logic [5:0]  hw_int,
  input  logic        eret,
  input  logic        mtc0_we,
  input  logic [4:0]  cp0_addr,
  input  logic [31:0] cp0_wdata,
  output logic [31:0] cp0_rdata,
  output logic        exc_flush,
  output logic [31:0] exc_target
);

  localparam logic [31:0] EXC_VECTOR = 32'hBFC0_0380;

  localparam logic [4:0] ADDR_BADVADDR = 5'd8;
  localparam logic [4:0] ADDR_COUNT    = 5'd9;
  localparam logic [4:0] ADDR_COMPARE  = 5'd11;
  localparam logic [4:0] ADDR_STATUS   = 5'd12;
  localparam logic [4:0] ADDR_CAUSE    = 5'd13;
  localparam logic [4:0] ADDR_EPC      = 5'd14;

  logic [31:0] badvaddr_reg;
  logic [31:0] count_reg;
  logic [31:0] compare_reg;
  logic [31:0] epc_reg;
  logic [7:0]  im_reg;
  logic        exl_reg;
  logic        ie_reg;
  logic        bd_reg;
  logic        ti_reg;
  logic [7:0]  ip_reg;
  logic [4:0]  exc_code_reg;
  logic        tick_reg;

  logic        int_req;
  logic        exc_taken;
  logic [4:0]  exc_code_sel;
  logic        wr_en;
  logic        wr_count;
  logic        wr_compare;

  assign int_req = ie_reg & ~exl_reg & (|(ip_reg & im_reg));

  // Fixed priority; the chain order is the architectural priority order.
  always_comb begin
    exc_code_sel = 5'd0;
    exc_taken    = 1'b1;
    if (int_req)           exc_code_sel = 5'd0;
    else if (exp_adel)     exc_code_sel = 5'd4;
    else if (exp_ri)       exc_code_sel = 5'd10;
    else if (exp_overflow) exc_code_sel = 5'd12;
    else if (exp_syscall)  exc_code_sel = 5'd8;
    else if (exp_break)    exc_code_sel = 5'd9;
    else if (exp_ades)     exc_code_sel = 5'd5;
    else                   exc_taken    = 1'b0;
    if (rst) exc_taken = 1'b0;
  end

  assign exc_flush  = ~rst & (exc_taken | eret);
  assign exc_target = exc_taken ? EXC_VECTOR : epc_reg;

  assign wr_en      = mtc0_we & ~exc_taken;
  assign wr_count   = wr_en & (cp0_addr == ADDR_COUNT);
  assign wr_compare = wr_en & (cp0_addr == ADDR_COMPARE);

  always_ff @(posedge clk) begin
    if (rst) begin
      badvaddr_reg <= '0;
      count_reg    <= '0;
      compare_reg  <= '0;
      epc_reg      <= '0;
      im_reg       <= '0;
      exl_reg      <= 1'b0;
      ie_reg       <= 1'b0;
      bd_reg       <= 1'b0;
      ti_reg       <= 1'b0;
      ip_reg       <= '0;
      exc_code_reg <= '0;
      tick_reg     <= 1'b0;
    end else begin
      // The timer shares hw_int[5]'s pending bit.
      ip_reg[7:2] <= {hw_int[5] | ti_reg, hw_int[4:0]};

      if (wr_count) begin
        count_reg <= cp0_wdata;
        tick_reg  <= 1'b0;
      end else begin
        tick_reg <= ~tick_reg;
        if (tick_reg) count_reg <= count_reg + 32'd1;
      end

      if (wr_compare) begin
        compare_reg <= cp0_wdata;
        ti_reg      <= 1'b0;
      end else if (count_reg == compare_reg) begin
        ti_reg <= 1'b1;
      end

      if (exc_taken) begin
        exc_code_reg <= exc_code_sel;
        exl_reg      <= 1'b1;
        // A nested exception keeps the original return point.
        if (!exl_reg) begin
          epc_reg <= in_delay_slot ? pc_i - 32'd4 : pc_i;
          bd_reg  <= in_delay_slot;
        end
        if (exc_code_sel == 5'd4 || exc_code_sel == 5'd5) badvaddr_reg <= bad_vaddr_i;
      end else if (eret) begin
        exl_reg <= 1'b0;
      end else if (wr_en) begin
        case (cp0_addr)
          ADDR_STATUS: begin
            im_reg  <= cp0_wdata[15:8];
            exl_reg <= cp0_wdata[1];
            ie_reg  <= cp0_wdata[0];
          end
          ADDR_CAUSE: ip_reg[1:0] <= cp0_wdata[9:8];
          ADDR_EPC:   epc_reg     <= cp0_wdata;
          default: ;
        endcase
      end
    end
  end

  always_comb begin
    cp0_rdata = 32'd0;
    case (cp0_addr)
      ADDR_BADVADDR: cp0_rdata = badvaddr_reg;
      ADDR_COUNT:    cp0_rdata = count_reg;
      ADDR_COMPARE:  cp0_rdata = compare_reg;
      ADDR_STATUS:   cp0_rdata = {9'd0, 1'b1, 6'd0, im_reg, 6'd0, exl_reg, ie_reg};
      ADDR_CAUSE:    cp0_rdata = {bd_reg, ti_reg, 14'd0, ip_reg, 1'b0, exc_code_reg, 2'b00};
      ADDR_EPC:      cp0_rdata = epc_reg;
      default:       cp0_rdata = 32'd0;
    endcase
  end

endmodule

// File: tb/tb_cp0_exc.sv
// Scoreboard bench for cp0_exc: directed scenarios plus random traffic, checked
// against an architectural register-array model of CP0.
module tb_cp0_exc;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] pc_i;
  logic        in_delay_slot;
  logic        exp_overflow, exp_syscall, exp_break, exp_ri, exp_adel, exp_ades;
  logic [31:0] bad_vaddr_i;
  logic [5:0]  hw_int;
  logic        eret;
  logic        mtc0_we;
  logic [4:0]  cp0_addr;
  logic [31:0] cp0_wdata;
  logic [31:0] cp0_rdata;
  logic        exc_flush;
  logic [31:0] exc_target;

  cp0_exc dut (
    .clk(clk), .rst(rst), .pc_i(pc_i), .in_delay_slot(in_delay_slot),
    .exp_overflow(exp_overflow), .exp_syscall(exp_syscall), .exp_break(exp_break),
    .exp_ri(exp_ri), .exp_adel(exp_adel), .exp_ades(exp_ades),
    .bad_vaddr_i(bad_vaddr_i), .hw_int(hw_int), .eret(eret),
    .mtc0_we(mtc0_we), .cp0_addr(cp0_addr), .cp0_wdata(cp0_wdata),
    .cp0_rdata(cp0_rdata), .exc_flush(exc_flush), .exc_target(exc_target)
  );

  always #5 clk = ~clk;

  localparam logic [31:0] VEC = 32'hBFC0_0380;

  typedef struct {
    logic        flush;
    logic [31:0] target;
    logic [31:0] rdata;
    logic [4:0]  addr;
    int          id;
  } exp_t;

  exp_t q[$];
  int total = 0;
  int bad = 0;
  int ncyc = 0;

  // Architectural model: CP0 registers indexed by register number.
  logic [31:0] m [0:31];
  bit          m_tick;

  task automatic reset_model();
    for (int i = 0; i < 32; i++) m[i] = 32'd0;
    m[12]  = 32'h0040_0000;
    m_tick = 1'b0;
  endtask

  task automatic idle();
    in_delay_slot = 1'b0;
    exp_overflow = 1'b0; exp_syscall = 1'b0; exp_break = 1'b0;
    exp_ri = 1'b0; exp_adel = 1'b0; exp_ades = 1'b0;
    eret = 1'b0; mtc0_we = 1'b0; cp0_wdata = 32'd0;
    bad_vaddr_i = $urandom;
    pc_i = $urandom & 32'hFFFF_FFFC;
  endtask

  // Predict this cycle's outputs, queue them, advance the model over the edge.
  task automatic step();
    exp_t        e;
    logic [31:0] n [0:31];
    logic [31:0] st, ca;
    logic [7:0]  ip;
    logic        ti, bd;
    logic [4:0]  code;
    bit   [6:0]  act;
    int          codes [7] = '{0, 4, 10, 12, 8, 9, 5};
    int          win;
    bit          ireq, exc, eff;
    st = m[12];
    ca = m[13];
    ireq = st[0] && !st[1] && ((ca[15:8] & st[15:8]) != 8'd0);
    act[0] = ireq; act[1] = exp_adel; act[2] = exp_ri; act[3] = exp_overflow;
    act[4] = exp_syscall; act[5] = exp_break; act[6] = exp_ades;
    win = -1;
    for (int i = 0; i < 7; i++) if (act[i] && win < 0) win = codes[i];
    exc = !rst && (win >= 0);
    e.flush  = !rst && (exc || eret);
    e.target = exc ? VEC : m[14];
    e.rdata  = m[cp0_addr];
    e.addr   = cp0_addr;
    e.id     = ncyc;
    q.push_back(e);
    if (rst) begin
      reset_model();
    end else begin
      n = m;
      eff = mtc0_we && !exc;
      if (eff && cp0_addr == 5'd9) begin
        n[9] = cp0_wdata;
        m_tick = 1'b0;
      end else begin
        if (m_tick) n[9] = m[9] + 32'd1;
        m_tick = !m_tick;
      end
      ti = ca[30];
      if (eff && cp0_addr == 5'd11) begin
        n[11] = cp0_wdata;
        ti = 1'b0;
      end else if (m[9] == m[11]) begin
        ti = 1'b1;
      end
      ip   = {hw_int[5] | ca[30], hw_int[4:0], ca[9:8]};
      bd   = ca[31];
      code = ca[6:2];
      if (exc) begin
        code = win[4:0];
        if (!st[1]) begin
          n[14] = in_delay_slot ? pc_i - 32'd4 : pc_i;
          bd = in_delay_slot;
        end
        n[12][1] = 1'b1;
        if (win == 4 || win == 5) n[8] = bad_vaddr_i;
      end else if (eret) begin
        n[12][1] = 1'b0;
      end else if (eff) begin
        case (cp0_addr)
          5'd12: n[12] = 32'h0040_0000 | (cp0_wdata & 32'h0000_FF03);
          5'd13: ip[1:0] = cp0_wdata[9:8];
          5'd14: n[14] = cp0_wdata;
          default: ;
        endcase
      end
      n[13] = {bd, ti, 14'd0, ip, 1'b0, code, 2'b00};
      m = n;
    end
    ncyc++;
    @(posedge clk);
    #1;
  endtask

  task automatic rd(input logic [4:0] a);
    idle();
    cp0_addr = a;
    step();
  endtask

  task automatic wr(input logic [4:0] a, input logic [31:0] d);
    idle();
    mtc0_we = 1'b1; cp0_addr = a; cp0_wdata = d;
    step();
  endtask

  // Monitor: outputs are stable mid-cycle, so compare on the falling edge.
  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      if (q.size() > 0) begin
        e = q.pop_front();
        total++;
        if (exc_flush !== e.flush) begin
          bad++;
          $display("FAIL flush cyc=%0d got=%0b want=%0b", e.id, exc_flush, e.flush);
        end
        if (e.flush) begin
          total++;
          if (exc_target !== e.target) begin
            bad++;
            $display("FAIL target cyc=%0d got=%h want=%h", e.id, exc_target, e.target);
          end
        end
        total++;
        if (cp0_rdata !== e.rdata) begin
          bad++;
          $display("FAIL rdata cyc=%0d addr=%0d got=%h want=%h", e.id, e.addr, cp0_rdata, e.rdata);
        end
      end
    end
  end

  initial begin : driver
    logic [4:0] ra [6] = '{5'd8, 5'd9, 5'd11, 5'd12, 5'd13, 5'd14};
    logic [4:0] wa [5] = '{5'd9, 5'd11, 5'd12, 5'd13, 5'd14};
    rst = 1'b1; hw_int = 6'd0; cp0_addr = 5'd12;
    idle();
    repeat (3) @(posedge clk);
    #1;
    reset_model();

    // Flags during reset must not flush.
    idle(); exp_overflow = 1'b1; exp_adel = 1'b1; cp0_addr = 5'd12; step();
    rst = 1'b0;
    rd(5'd13);

    // Overflow, not in a delay slot.
    idle(); exp_overflow = 1'b1; pc_i = 32'h8000_1000; cp0_addr = 5'd14; step();
    rd(5'd14); rd(5'd13); rd(5'd12);
    idle(); eret = 1'b1; cp0_addr = 5'd12; step();

    // Syscall in a delay slot beats a simultaneous AdES.
    idle(); exp_syscall = 1'b1; exp_ades = 1'b1; in_delay_slot = 1'b1;
    pc_i = 32'h8000_2004; cp0_addr = 5'd8; step();
    rd(5'd14); rd(5'd13); rd(5'd8);

    // Nested RI while EXL=1, then eret back to the saved EPC.
    idle(); exp_ri = 1'b1; pc_i = 32'h8000_3000; step();
    rd(5'd14); rd(5'd13);
    idle(); eret = 1'b1; cp0_addr = 5'd12; step();
    rd(5'd12);

    // Interrupt beats a same-cycle AdEL.
    wr(5'd12, 32'h0000_0401);
    hw_int = 6'b000001;
    rd(5'd13);
    idle(); exp_adel = 1'b1; cp0_addr = 5'd13; step();
    rd(5'd13); rd(5'd8);
    hw_int = 6'd0;
    idle(); eret = 1'b1; step();
    wr(5'd12, 32'h0000_0000);

    // Timer match, Compare write clearing TI, Count wrap.
    wr(5'd11, 32'd10);
    wr(5'd9, 32'd0);
    for (int i = 0; i < 26; i++) rd((i % 2 == 0) ? 5'd13 : 5'd9);
    wr(5'd11, 32'd20);
    rd(5'd13);
    wr(5'd9, 32'hFFFF_FFFF);
    rd(5'd9); rd(5'd9); rd(5'd9);

    // mtc0 to EPC dropped under an overflow, then reset mid-operation.
    idle(); mtc0_we = 1'b1; cp0_addr = 5'd14; cp0_wdata = 32'h1234_5678;
    exp_overflow = 1'b1; pc_i = 32'h8000_4000; step();
    rd(5'd14);
    rst = 1'b1;
    idle(); exp_overflow = 1'b1; eret = 1'b1; cp0_addr = 5'd14; step();
    for (int i = 0; i < 6; i++) begin
      idle(); exp_syscall = 1'b1; cp0_addr = ra[i]; step();
    end
    rst = 1'b0;

    // Random traffic.
    for (int c = 0; c < 3000; c++) begin
      idle();
      rst = ($urandom_range(0, 299) == 0);
      in_delay_slot = $urandom_range(0, 1);
      exp_overflow = ($urandom_range(0, 19) == 0);
      exp_syscall  = ($urandom_range(0, 19) == 0);
      exp_break    = ($urandom_range(0, 19) == 0);
      exp_ri       = ($urandom_range(0, 19) == 0);
      exp_adel     = ($urandom_range(0, 19) == 0);
      exp_ades     = ($urandom_range(0, 19) == 0);
      if ($urandom_range(0, 7) == 0) hw_int = ($urandom_range(0, 1) == 0) ? 6'd0 : 6'($urandom);
      cp0_addr = ($urandom_range(0, 2) != 0) ? ra[$urandom_range(0, 5)] : 5'($urandom);
      if ($urandom_range(0, 9) == 0) begin
        eret = 1'b1;
      end else if ($urandom_range(0, 4) == 0) begin
        mtc0_we = 1'b1;
        cp0_addr = wa[$urandom_range(0, 4)];
        cp0_wdata = $urandom;
      end
      step();
    end
    rst = 1'b0;
    idle();

    repeat (2) @(negedge clk);
    total++;
    if (q.size() != 0) begin
      bad++;
      $display("FAIL drain pending=%0d want=0", q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
